flag_unit: RTL and testbench

- Produces and holds the 4-bit processor status flags that the branch-decision logic consumes.
- Bit order: [0] overflow, [1] carry, [2] zero, [3] negative.
- Computes the flags from each ALU result and writes them under a per-instruction mask.
- Supports direct flag load and a small save/restore stack for interrupt entry and exit. Sits between the ALU and the branch decision logic.

---
 rtl/flag_unit.sv | 109 ++++++++++
 tb/tb_flag_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// Processor status flag register: computes N/Z/C/V from ALU results under a
// per-bit write mask, with direct load and a small save/restore stack.
module flag_unit #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           alu_valid,
  input  logic [1:0]                     alu_op,
  input  logic [WIDTH-1:0]               op_a,
  input  logic [WIDTH-1:0]               op_b,
  input  logic [WIDTH-1:0]               alu_result,
  input  logic                           carry_out,
  input  logic [3:0]                     flag_mask,
  input  logic                           flags_load,
  input  logic [3:0]                     flags_din,
  input  logic                           push,
  input  logic                           pop,
  output logic [3:0]                     flags,
  output logic                           flags_updated,
  output logic [$clog2(STACK_DEPTH):0]   stack_level,
  output logic                           stack_err
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(STACK_DEPTH);

  logic [3:0]  flags_q, flags_d;
  logic        upd_q, upd_d;
  logic        err_q, err_d;
  logic [AW:0] level_q, level_d;
  logic [3:0]  stack_q [STACK_DEPTH];
  logic [3:0]  stack_d [STACK_DEPTH];

  logic        a_msb, b_msb, r_msb;
  logic        cy, ovf;
  logic [3:0]  alu_flags, alu_masked;
  logic        alu_wr;
  logic        push_ok, pop_ok;
  logic        full, empty;
  logic [AW:0] level_m1;

  always_comb begin
    a_msb = op_a[WIDTH-1];
    b_msb = op_b[WIDTH-1];
    r_msb = alu_result[WIDTH-1];
    cy    = carry_out;
    ovf   = 1'b0;
    case (alu_op)
      2'b00:   ovf = (a_msb == b_msb) && (r_msb != a_msb);
      2'b01:   ovf = (a_msb != b_msb) && (r_msb != a_msb);
      2'b10:   cy  = 1'b0;
      default: ovf = 1'b0;
    endcase
    alu_flags  = {r_msb, (alu_result == '0), cy, ovf};
    alu_masked = (flag_mask & alu_flags) | (~flag_mask & flags_q);
    alu_wr     = alu_valid && (flag_mask != 4'b0000);
  end

  // Simultaneous push and pop cancel each other; only the error is reported.
  always_comb begin
    full     = (level_q == FULL_LEVEL);
    empty    = (level_q == '0);
    level_m1 = level_q - 1'b1;
    push_ok  = push && !pop && !full;
    pop_ok   = pop && !push && !empty;
    err_d    = (push && pop) || (push && !pop && full) || (pop && !push && empty);

    level_d = level_q;
    if (push_ok) level_d = level_q + 1'b1;
    else if (pop_ok) level_d = level_m1;

    stack_d = stack_q;
    if (push_ok) stack_d[level_q[AW-1:0]] = flags_q;

    flags_d = flags_q;
    upd_d   = 1'b1;
    if (pop_ok) flags_d = stack_q[level_m1[AW-1:0]];
    else if (flags_load) flags_d = flags_din;
    else if (alu_wr) flags_d = alu_masked;
    else upd_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      level_q <= '0;
    end else begin
      flags_q <= flags_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      level_q <= level_d;
    end
  end

  // Stack contents need no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign flags         = flags_q;
  assign flags_updated = upd_q;
  assign stack_level   = level_q;
  assign stack_err     = err_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed self-checking bench for flag_unit (WIDTH=16, STACK_DEPTH=4).
module tb_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [1:0]  alu_op;
  logic [15:0] op_a, op_b, alu_result;
  logic        carry_out;
  logic [3:0]  flag_mask;
  logic        flags_load;
  logic [3:0]  flags_din;
  logic        push, pop;
  logic [3:0]  flags;
  logic        flags_updated;
  logic [2:0]  stack_level;
  logic        stack_err;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  flag_unit #(.WIDTH(16), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_op(alu_op),
    .op_a(op_a), .op_b(op_b), .alu_result(alu_result), .carry_out(carry_out),
    .flag_mask(flag_mask), .flags_load(flags_load), .flags_din(flags_din),
    .push(push), .pop(pop), .flags(flags), .flags_updated(flags_updated),
    .stack_level(stack_level), .stack_err(stack_err)
  );

  task automatic idle();
    alu_valid = 0; alu_op = 2'b00; op_a = '0; op_b = '0; alu_result = '0;
    carry_out = 0; flag_mask = 4'b0000; flags_load = 0; flags_din = 4'b0000;
    push = 0; pop = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] r, input logic c, input logic [3:0] m);
    alu_valid = 1; alu_op = op; op_a = a; op_b = b; alu_result = r;
    carry_out = c; flag_mask = m;
  endtask

  task automatic do_reset();
    idle(); rst_n = 0; step(); step(); rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 1; idle();
    for (int i = 0; i < 6; i++) begin
      flags_load = 1; flags_din = 4'($urandom); push = 1; step();
    end
    rst_n = 0; push = 1; flags_load = 1; flags_din = 4'b1111; pop = 0;
    step(); step();
    vec++; if (flags !== 4'b0000) begin miss++; $display("FAIL reset_flags got %b exp 0000", flags); end
    vec++; if (stack_level !== 3'd0) begin miss++; $display("FAIL reset_level got %0d exp 0", stack_level); end
    vec++; if (flags_updated !== 1'b0) begin miss++; $display("FAIL reset_upd got %b exp 0", flags_updated); end
    vec++; if (stack_err !== 1'b0) begin miss++; $display("FAIL reset_err got %b exp 0", stack_err); end
    rst_n = 1; idle(); step();
    vec++; if (flags_updated !== 1'b0 || flags !== 4'b0000) begin miss++; $display("FAIL post_reset_idle got upd=%b flags=%b exp upd=0 flags=0000", flags_updated, flags); end
  endtask

  task automatic test_alu();
    alu(2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 4'b1111); step();
    vec++; if (flags !== 4'b1001) begin miss++; $display("FAIL add_ovf got %b exp 1001", flags); end
    vec++; if (flags_updated !== 1'b1) begin miss++; $display("FAIL add_ovf_upd got %b exp 1", flags_updated); end
    alu(2'b01, 16'h1234, 16'h1234, 16'h0000, 1'b1, 4'b0110); step();
    vec++; if (flags !== 4'b1111) begin miss++; $display("FAIL sub_zero_mask got %b exp 1111", flags); end
    alu(2'b10, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b1, 4'b1111); step();
    vec++; if (flags !== 4'b0100) begin miss++; $display("FAIL logic_op got %b exp 0100", flags); end
    alu(2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 4'b0000); step();
    vec++; if (flags !== 4'b0100) begin miss++; $display("FAIL mask_zero got %b exp 0100", flags); end
    vec++; if (flags_updated !== 1'b0) begin miss++; $display("FAIL mask_zero_upd got %b exp 0", flags_updated); end
    alu(2'b11, 16'hC000, 16'h0001, 16'h8000, 1'b1, 4'b1111); step();
    vec++; if (flags !== 4'b1010) begin miss++; $display("FAIL shift got %b exp 1010", flags); end
    alu(2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 4'b1111); step();
    vec++; if (flags !== 4'b0001) begin miss++; $display("FAIL sub_ovf got %b exp 0001", flags); end
    alu(2'b00, 16'h4000, 16'h4000, 16'h8000, 1'b0, 4'b0001); step();
    vec++; if (flags !== 4'b0001) begin miss++; $display("FAIL add_ovf_vonly got %b exp 0001", flags); end
    alu(2'b00, 16'h8000, 16'h8000, 16'h0000, 1'b1, 4'b1111); step();
    vec++; if (flags !== 4'b0111) begin miss++; $display("FAIL add_neg_ovf got %b exp 0111", flags); end
    idle(); step();
    vec++; if (flags_updated !== 1'b0) begin miss++; $display("FAIL idle_upd got %b exp 0", flags_updated); end
  endtask

  task automatic test_stack();
    do_reset();
    flags_load = 1; flags_din = 4'b1010; step(); idle();
    push = 1; step(); idle();
    vec++; if (stack_level !== 3'd1 || flags_updated !== 1'b0) begin miss++; $display("FAIL push1 got lvl=%0d upd=%b exp lvl=1 upd=0", stack_level, flags_updated); end
    flags_load = 1; flags_din = 4'b0101; step(); idle();
    push = 1; step(); idle();
    vec++; if (stack_level !== 3'd2) begin miss++; $display("FAIL push2 got lvl=%0d exp 2", stack_level); end
    pop = 1; step(); idle();
    vec++; if (flags !== 4'b0101 || stack_level !== 3'd1) begin miss++; $display("FAIL pop1 got flags=%b lvl=%0d exp 0101 lvl=1", flags, stack_level); end
    vec++; if (flags_updated !== 1'b1) begin miss++; $display("FAIL pop1_upd got %b exp 1", flags_updated); end
    pop = 1; step(); idle();
    vec++; if (flags !== 4'b1010 || stack_level !== 3'd0) begin miss++; $display("FAIL pop2 got flags=%b lvl=%0d exp 1010 lvl=0", flags, stack_level); end
    pop = 1; step(); idle();
    vec++; if (stack_err !== 1'b1 || flags !== 4'b1010 || stack_level !== 3'd0) begin miss++; $display("FAIL pop_empty got err=%b flags=%b lvl=%0d exp err=1 1010 lvl=0", stack_err, flags, stack_level); end
    step();
    vec++; if (stack_err !== 1'b0) begin miss++; $display("FAIL err_pulse got %b exp 0", stack_err); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) begin
      push = 1; step(); idle();
      vec++; if (stack_level !== 3'(i) || stack_err !== 1'b0) begin miss++; $display("FAIL fill_%0d got lvl=%0d err=%b exp lvl=%0d err=0", i, stack_level, stack_err, i); end
    end
    push = 1; step(); idle();
    vec++; if (stack_err !== 1'b1 || stack_level !== 3'd4) begin miss++; $display("FAIL push_full got err=%b lvl=%0d exp err=1 lvl=4", stack_err, stack_level); end
    push = 1; pop = 1; step(); idle();
    vec++; if (stack_err !== 1'b1 || stack_level !== 3'd4 || flags !== 4'b1010) begin miss++; $display("FAIL push_pop got err=%b lvl=%0d flags=%b exp err=1 lvl=4 1010", stack_err, stack_level, flags); end
  endtask

  task automatic test_priority();
    flags_load = 1; flags_din = 4'b0011; step(); idle();
    pop = 1; flags_load = 1; flags_din = 4'b0101;
    alu(2'b10, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4'b1111); step(); idle();
    vec++; if (flags !== 4'b1010 || stack_level !== 3'd3) begin miss++; $display("FAIL pop_wins got flags=%b lvl=%0d exp 1010 lvl=3", flags, stack_level); end
    flags_load = 1; flags_din = 4'b1100;
    alu(2'b10, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4'b1111); step(); idle();
    vec++; if (flags !== 4'b1100) begin miss++; $display("FAIL load_over_alu got %b exp 1100", flags); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    flags_load = 1; flags_din = 4'b0110; step(); idle();
    push = 1; flags_load = 1; flags_din = 4'b1001; step(); idle();
    vec++; if (flags !== 4'b1001 || stack_level !== 3'd1) begin miss++; $display("FAIL push_load got flags=%b lvl=%0d exp 1001 lvl=1", flags, stack_level); end
    pop = 1; step(); idle();
    vec++; if (flags !== 4'b0110) begin miss++; $display("FAIL pre_update_saved got %b exp 0110", flags); end
    pop = 1; flags_load = 1; flags_din = 4'b1110; step(); idle();
    vec++; if (stack_err !== 1'b1 || flags !== 4'b1110 || flags_updated !== 1'b1) begin miss++; $display("FAIL failed_pop_load got err=%b flags=%b upd=%b exp err=1 1110 upd=1", stack_err, flags, flags_updated); end
    pop = 1; alu(2'b00, 16'h0001, 16'h0001, 16'h0002, 1'b0, 4'b1111); step(); idle();
    vec++; if (stack_err !== 1'b1 || flags !== 4'b0000) begin miss++; $display("FAIL failed_pop_alu got err=%b flags=%b exp err=1 0000", stack_err, flags); end
    push = 1; step(); idle();
    pop = 1; rst_n = 0; step(); rst_n = 1; idle();
    vec++; if (stack_level !== 3'd0 || flags !== 4'b0000) begin miss++; $display("FAIL reset_mid_pop got lvl=%0d flags=%b exp lvl=0 0000", stack_level, flags); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_stack();
    test_overflow();
    test_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
